data_mem_unit: RTL and testbench

Data-memory stage directly downstream of the pipeline core's EX/MEM outputs. It consumes the EX/MEM ALU result (address), EX/MEM store data and the MemRead/MemWrite strobes, and returns read data to the MEM/WB path the same cycle. The block holds the word-addressed data RAM and a small memory-mapped register window: cycle counter, access counters, scratch register and a sticky access-error status.

---
 rtl/data_mem_unit.sv | 101 ++++++++++
 tb/tb_data_mem_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_unit.sv
// Data-memory stage: word-addressed RAM plus a small MMIO register window holding
// cycle/access counters, a scratch register and a sticky access-error status.
module data_mem_unit #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Memread,
  input  logic        Memwrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Memory_out,
  output logic        Mem_err,
  output logic [31:0] Err_addr
);

  localparam int unsigned ADDR_W    = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);
  localparam logic [31:0] MMIO_SIZE = 32'h14;

  typedef enum logic [2:0] {
    RegCycle   = 3'd0,
    RegRdcnt   = 3'd1,
    RegWrcnt   = 3'd2,
    RegScratch = 3'd3,
    RegStatus  = 3'd4
  } reg_e;

  logic [31:0] mem [DEPTH];
  logic [31:0] cycle_q, rdcnt_q, wrcnt_q, scratch_q, err_addr_q;
  logic        err_q;

  logic [31:0]       mmio_off, mmio_rdata, rdata;
  logic              misaligned, mmio_sel, ram_sel, legal, fault, rd_ok, wr_ok;
  logic              status_clr;
  reg_e              reg_sel;
  logic [ADDR_W-1:0] word_idx;

  // Unsigned offset compare also rejects addresses below the window via wrap-around.
  always_comb begin
    mmio_off   = Address - MMIO_BASE;
    misaligned = Address[1:0] != 2'b00;
    mmio_sel   = !misaligned && (mmio_off < MMIO_SIZE);
    ram_sel    = !misaligned && !mmio_sel && (Address < RAM_BYTES);
    legal      = mmio_sel || ram_sel;
    fault      = (Memread || Memwrite) && !legal;
    rd_ok      = Memread && legal;
    wr_ok      = Memwrite && legal;
    reg_sel    = reg_e'(mmio_off[4:2]);
    word_idx   = Address[ADDR_W+1:2];
    status_clr = wr_ok && mmio_sel && (reg_sel == RegStatus) && Write_data[0];
  end

  always_comb begin
    mmio_rdata = '0;
    case (reg_sel)
      RegCycle:   mmio_rdata = cycle_q;
      RegRdcnt:   mmio_rdata = rdcnt_q;
      RegWrcnt:   mmio_rdata = wrcnt_q;
      RegScratch: mmio_rdata = scratch_q;
      RegStatus:  mmio_rdata = {31'b0, err_q};
      default:    mmio_rdata = '0;
    endcase
    rdata      = mmio_sel ? mmio_rdata : mem[word_idx];
    Memory_out = (rst || !rd_ok) ? '0 : rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q    <= '0;
      rdcnt_q    <= '0;
      wrcnt_q    <= '0;
      scratch_q  <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (rd_ok) rdcnt_q <= rdcnt_q + 32'd1;
      if (wr_ok) wrcnt_q <= wrcnt_q + 32'd1;
      if (wr_ok && mmio_sel && (reg_sel == RegScratch)) scratch_q <= Write_data;
      // Only the first fault since the last clear is recorded.
      if (fault && !err_q) begin
        err_q      <= 1'b1;
        err_addr_q <= Address;
      end else if (status_clr) begin
        err_q      <= 1'b0;
        err_addr_q <= '0;
      end
    end
  end

  // RAM contents survive reset, but a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok && ram_sel) mem[word_idx] <= Write_data;
  end

  assign Mem_err  = err_q;
  assign Err_addr = err_addr_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: directed sequences, a vector table and randomized
// traffic checked against an array/counter reference model.
module tb_data_mem_unit;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst, Memread, Memwrite, Mem_err;
  logic [31:0] Address, Write_data, Memory_out, Err_addr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_mem_unit #(
    .DEPTH    (256),
    .MMIO_BASE(BASE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Memread   (Memread),
    .Memwrite  (Memwrite),
    .Address   (Address),
    .Write_data(Write_data),
    .Memory_out(Memory_out),
    .Mem_err   (Mem_err),
    .Err_addr  (Err_addr)
  );

  // Reference model state
  logic [31:0] mem_m [int];
  logic [31:0] cyc_m, rd_m, wr_m, scr_m, eaddr_m;
  logic        err_m;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] out;
    logic        err;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // 0 = RAM, 1 = MMIO, 2 = fault
  function automatic int kind_of(input logic [31:0] a);
    if (a % 4 != 0) return 2;
    if (longint'(a) >= longint'(BASE) && longint'(a) < longint'(BASE) + 20) return 1;
    if (a < 32'd1024) return 0;
    return 2;
  endfunction

  function automatic void model_reset();
    cyc_m = 0; rd_m = 0; wr_m = 0; scr_m = 0; err_m = 0; eaddr_m = 0;
  endfunction

  function automatic void model_read(input logic rd, input logic [31:0] a,
                                     output logic [31:0] exp, output logic known);
    exp   = '0;
    known = 1'b1;
    if (!rd) return;
    case (kind_of(a))
      0: if (mem_m.exists(int'(a >> 2))) exp = mem_m[int'(a >> 2)]; else known = 1'b0;
      1: begin
        case (a - BASE)
          32'd0:   exp = cyc_m;
          32'd4:   exp = rd_m;
          32'd8:   exp = wr_m;
          32'd12:  exp = scr_m;
          default: exp = {31'b0, err_m};
        endcase
      end
      default: exp = '0;
    endcase
  endfunction

  function automatic void model_step(input logic rd, input logic wr, input logic [31:0] a,
                                     input logic [31:0] wd);
    int k = kind_of(a);
    if ((rd || wr) && k == 2 && !err_m) begin
      err_m   = 1'b1;
      eaddr_m = a;
    end
    if (wr && k == 0) mem_m[int'(a >> 2)] = wd;
    if (wr && k == 1 && a - BASE == 32'd12) scr_m = wd;
    if (wr && k == 1 && a - BASE == 32'd16 && wd[0]) begin
      err_m   = 1'b0;
      eaddr_m = '0;
    end
    if (rd && k != 2) rd_m++;
    if (wr && k != 2) wr_m++;
    cyc_m++;
  endfunction

  // One bus cycle; starts and ends 1 time unit after a rising edge.
  task automatic cyc(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] o, output logic e, output logic [31:0] ea);
    Memread = rd; Memwrite = wr; Address = a; Write_data = wd;
    #2 o = Memory_out;
    @(posedge clk);
    #1;
    model_step(rd, wr, a, wd);
    e  = Mem_err;
    ea = Err_addr;
  endtask

  task automatic step_exp(input string nm, input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_out,
                          input logic exp_err, input logic [31:0] exp_ea);
    logic [31:0] o, ea;
    logic        e;
    cyc(rd, wr, a, wd, o, e, ea);
    chk({nm, ".out"}, o, exp_out);
    chk({nm, ".err"}, {31'b0, e}, {31'b0, exp_err});
    chk({nm, ".eaddr"}, ea, exp_ea);
  endtask

  task automatic idle();
    logic [31:0] o, ea;
    logic        e;
    cyc(1'b0, 1'b0, 32'h0, 32'h0, o, e, ea);
  endtask

  task automatic do_reset();
    rst = 1'b1; Memread = 1'b0; Memwrite = 1'b0; Address = '0; Write_data = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, wd, exp, o, ea;
    logic        rd, wr, known, e;

    rst = 1'b1; Memread = 1'b0; Memwrite = 1'b0; Address = '0; Write_data = '0;
    model_reset();

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'h1234_5678, 32'h0,          1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         32'h1234_5678, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         32'h0,          1'b1, 32'h400};
    vecs[3]  = '{1'b0, 1'b1, 32'hFFFF_0014, 32'h9,         32'h0,          1'b1, 32'h400};
    vecs[4]  = '{1'b0, 1'b1, 32'hFFFF_0010, 32'h1,         32'h0,          1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 32'hFFFF_000C, 32'hCAFE_F00D, 32'h0,          1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'hFFFF_000C, 32'h0,         32'hCAFE_F00D, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'hFFFF_0012, 32'h0,         32'h0,          1'b1, 32'hFFFF_0012};
    vecs[8]  = '{1'b1, 1'b0, 32'hFFFF_0010, 32'h0,         32'h1,          1'b1, 32'hFFFF_0012};
    vecs[9]  = '{1'b0, 1'b1, 32'hFFFF_0010, 32'h3,         32'h0,          1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 32'hFFFF_0008, 32'h55,        32'h0,          1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 32'h0000_03FC, 32'h0,         32'h0,          1'b0, 32'h0};
    vecs[12] = '{1'b0, 1'b1, 32'hFFFE_FFFC, 32'h7,         32'h0,          1'b1, 32'hFFFE_FFFC};
    vecs[13] = '{1'b0, 1'b1, 32'hFFFF_0010, 32'h1,         32'h0,          1'b0, 32'h0};

    // Cycle counter after reset release, RO write, scratch round-trip
    do_reset();
    chk("rst.out", Memory_out, 32'h0);
    chk("rst.err", {31'b0, Mem_err}, 32'h0);
    chk("rst.eaddr", Err_addr, 32'h0);
    repeat (10) idle();
    step_exp("t5.cycle", 1'b1, 1'b0, BASE, 32'h0, 32'd10, 1'b0, 32'h0);
    step_exp("t5.ro_wr", 1'b0, 1'b1, BASE, 32'h55, 32'h0, 1'b0, 32'h0);
    step_exp("t5.scr_wr", 1'b0, 1'b1, BASE + 32'hC, 32'hA5A5_A5A5, 32'h0, 1'b0, 32'h0);
    step_exp("t5.scr_rd", 1'b1, 1'b0, BASE + 32'hC, 32'h0, 32'hA5A5_A5A5, 1'b0, 32'h0);
    step_exp("t5.cycle2", 1'b1, 1'b0, BASE, 32'h0, 32'd14, 1'b0, 32'h0);

    // Basic write/read and access counters
    do_reset();
    step_exp("t1.wr", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 32'h0);
    step_exp("t1.rd", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0);
    step_exp("t1.rdcnt", 1'b1, 1'b0, BASE + 32'h4, 32'h0, 32'd1, 1'b0, 32'h0);
    step_exp("t1.wrcnt", 1'b1, 1'b0, BASE + 32'h8, 32'h0, 32'd1, 1'b0, 32'h0);

    // Faults: first address captured, not counted
    step_exp("t2.mis", 1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 32'h13);
    step_exp("t2.oor", 1'b1, 1'b0, 32'h2000, 32'h0, 32'h0, 1'b1, 32'h13);
    step_exp("t2.rdcnt", 1'b1, 1'b0, BASE + 32'h4, 32'h0, 32'd3, 1'b1, 32'h13);

    // STATUS clear semantics
    step_exp("t3.wr0", 1'b0, 1'b1, BASE + 32'h10, 32'h0, 32'h0, 1'b1, 32'h13);
    step_exp("t3.rd1", 1'b1, 1'b0, BASE + 32'h10, 32'h0, 32'h1, 1'b1, 32'h13);
    step_exp("t3.wr1", 1'b0, 1'b1, BASE + 32'h10, 32'h1, 32'h0, 1'b0, 32'h0);
    step_exp("t3.rd0", 1'b1, 1'b0, BASE + 32'h10, 32'h0, 32'h0, 1'b0, 32'h0);

    // Simultaneous read and write returns pre-write data
    step_exp("t4.init", 1'b0, 1'b1, 32'h20, 32'h11, 32'h0, 1'b0, 32'h0);
    step_exp("t4.rw", 1'b1, 1'b1, 32'h20, 32'h22, 32'h11, 1'b0, 32'h0);
    step_exp("t4.after", 1'b1, 1'b0, 32'h20, 32'h0, 32'h22, 1'b0, 32'h0);

    for (int i = 0; i < 14; i++) begin
      step_exp($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd,
               vecs[i].out, vecs[i].err, vecs[i].eaddr);
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: a = 32'($urandom_range(0, 31)) * 32'd4;
        5:             a = 32'($urandom_range(0, 255)) * 32'd4;
        6, 7:          a = BASE + 32'($urandom_range(0, 4)) * 32'd4;
        8:             a = 32'($urandom_range(0, 255)) * 32'd4 + 32'($urandom_range(1, 3));
        default:       a = 32'h400 + 32'($urandom_range(0, 100000)) * 32'd4;
      endcase
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom();
      model_read(rd, a, exp, known);
      cyc(rd, wr, a, wd, o, e, ea);
      if (known) chk($sformatf("rnd%0d.out a=%h", i, a), o, exp);
      chk($sformatf("rnd%0d.err", i), {31'b0, e}, {31'b0, err_m});
      chk($sformatf("rnd%0d.eaddr", i), ea, eaddr_m);
    end

    // Reset in the middle of a write burst
    step_exp("t6.clr", 1'b0, 1'b1, BASE + 32'h10, 32'h1, 32'h0, 1'b0, 32'h0);
    step_exp("t6.w0", 1'b0, 1'b1, 32'h100, 32'h1111, 32'h0, 1'b0, 32'h0);
    step_exp("t6.scr", 1'b0, 1'b1, BASE + 32'hC, 32'h77, 32'h0, 1'b0, 32'h0);
    step_exp("t6.flt", 1'b0, 1'b1, 32'h3, 32'h5, 32'h0, 1'b1, 32'h3);
    step_exp("t6.w1", 1'b0, 1'b1, 32'h104, 32'h4444, 32'h0, 1'b1, 32'h3);
    Memread = 1'b1; Memwrite = 1'b1; Address = 32'h100; Write_data = 32'h2222;
    #2 chk("t6.pre_out", Memory_out, 32'h1111);
    rst = 1'b1;
    model_reset();
    #1;
    chk("t6.rst_out", Memory_out, 32'h0);
    chk("t6.rst_err", {31'b0, Mem_err}, 32'h0);
    chk("t6.rst_eaddr", Err_addr, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    Memwrite = 1'b0;
    rst = 1'b0;
    step_exp("t6.cycle", 1'b1, 1'b0, BASE, 32'h0, 32'd0, 1'b0, 32'h0);
    step_exp("t6.rdcnt", 1'b1, 1'b0, BASE + 32'h4, 32'h0, 32'd1, 1'b0, 32'h0);
    step_exp("t6.wrcnt", 1'b1, 1'b0, BASE + 32'h8, 32'h0, 32'd0, 1'b0, 32'h0);
    step_exp("t6.scratch", 1'b1, 1'b0, BASE + 32'hC, 32'h0, 32'h0, 1'b0, 32'h0);
    step_exp("t6.status", 1'b1, 1'b0, BASE + 32'h10, 32'h0, 32'h0, 1'b0, 32'h0);
    step_exp("t6.ram0", 1'b1, 1'b0, 32'h100, 32'h0, 32'h1111, 1'b0, 32'h0);
    step_exp("t6.ram1", 1'b1, 1'b0, 32'h104, 32'h0, 32'h4444, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
